// File: rtl/shop_v.sv
// Command-driven shop database: user table, item table and one login session.
// Optional WHOAMI opcode (8) is enabled by defining SHOP_WHOAMI_EN.
module shop_v #(
  parameter int unsigned I_A_NUM_BITS = 24,
  parameter int unsigned I_U_NUM_BITS = 4,
  parameter int unsigned O_A_NUM_BITS = 24,
  parameter int unsigned MAX_USERS    = 5,
  parameter int unsigned MAX_ITEMS    = 8,
  parameter logic [I_A_NUM_BITS-1:0] ADMIN_USERNAME = "Adm"
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_rdy,
  input  logic [I_U_NUM_BITS-1:0] i_u,
  input  logic [I_A_NUM_BITS-1:0] i_a,
  output logic [O_A_NUM_BITS-1:0] o_a
);

  localparam int unsigned UW = $clog2(MAX_USERS);
  localparam int unsigned IW = $clog2(MAX_ITEMS);

  localparam logic [O_A_NUM_BITS-1:0] ST_OK  = "OK ";
  localparam logic [O_A_NUM_BITS-1:0] ST_DEN = "DEN";
  localparam logic [O_A_NUM_BITS-1:0] ST_NF  = "NF ";
  localparam logic [O_A_NUM_BITS-1:0] ST_DUP = "DUP";
  localparam logic [O_A_NUM_BITS-1:0] ST_FUL = "FUL";
  localparam logic [O_A_NUM_BITS-1:0] ST_ERR = "ERR";

  localparam logic [I_U_NUM_BITS-1:0] OP_NONE     = I_U_NUM_BITS'(0);
  localparam logic [I_U_NUM_BITS-1:0] OP_LOGIN    = I_U_NUM_BITS'(1);
  localparam logic [I_U_NUM_BITS-1:0] OP_LOGOUT   = I_U_NUM_BITS'(2);
  localparam logic [I_U_NUM_BITS-1:0] OP_ADD_USER = I_U_NUM_BITS'(3);
  localparam logic [I_U_NUM_BITS-1:0] OP_DEL_USER = I_U_NUM_BITS'(4);
  localparam logic [I_U_NUM_BITS-1:0] OP_ADD_ITEM = I_U_NUM_BITS'(5);
  localparam logic [I_U_NUM_BITS-1:0] OP_DEL_ITEM = I_U_NUM_BITS'(6);
  localparam logic [I_U_NUM_BITS-1:0] OP_BUY      = I_U_NUM_BITS'(7);
`ifdef SHOP_WHOAMI_EN
  localparam logic [I_U_NUM_BITS-1:0] OP_WHOAMI   = I_U_NUM_BITS'(8);
  localparam logic [O_A_NUM_BITS-1:0] ST_ANON     = "---";
`endif

  logic [I_A_NUM_BITS-1:0] user_name_q [MAX_USERS];
  logic [I_A_NUM_BITS-1:0] user_name_d [MAX_USERS];
  logic [MAX_USERS-1:0]    user_vld_q, user_vld_d;
  logic [I_A_NUM_BITS-1:0] item_name_q [MAX_ITEMS];
  logic [I_A_NUM_BITS-1:0] item_name_d [MAX_ITEMS];
  logic [MAX_ITEMS-1:0]    item_vld_q, item_vld_d;
  logic                    logged_q, logged_d;
  logic [UW-1:0]           sess_q, sess_d;
  logic [O_A_NUM_BITS-1:0] o_a_q, o_a_d;
  logic                    rdy_q;

  logic          accept, is_admin;
  logic          usr_hit, usr_free, itm_hit, itm_free;
  logic [UW-1:0] usr_hit_idx, usr_free_idx;
  logic [IW-1:0] itm_hit_idx, itm_free_idx;

  assign accept   = i_rdy & ~rdy_q;
  assign is_admin = logged_q & (sess_q == '0);
  assign o_a      = o_a_q;

  // Descending scans so the lowest matching / free slot wins.
  always_comb begin
    usr_hit      = 1'b0;
    usr_hit_idx  = '0;
    usr_free     = 1'b0;
    usr_free_idx = '0;
    for (int i = int'(MAX_USERS) - 1; i >= 0; i--) begin
      if (user_vld_q[i] && user_name_q[i] == i_a) begin
        usr_hit     = 1'b1;
        usr_hit_idx = UW'(i);
      end
      if (!user_vld_q[i]) begin
        usr_free     = 1'b1;
        usr_free_idx = UW'(i);
      end
    end
    itm_hit      = 1'b0;
    itm_hit_idx  = '0;
    itm_free     = 1'b0;
    itm_free_idx = '0;
    for (int i = int'(MAX_ITEMS) - 1; i >= 0; i--) begin
      if (item_vld_q[i] && item_name_q[i] == i_a) begin
        itm_hit     = 1'b1;
        itm_hit_idx = IW'(i);
      end
      if (!item_vld_q[i]) begin
        itm_free     = 1'b1;
        itm_free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    user_name_d = user_name_q;
    user_vld_d  = user_vld_q;
    item_name_d = item_name_q;
    item_vld_d  = item_vld_q;
    logged_d    = logged_q;
    sess_d      = sess_q;
    o_a_d       = o_a_q;
    if (accept) begin
      if (i_u != OP_NONE && i_u != OP_LOGOUT && i_a == '0) begin
        o_a_d = ST_ERR;
      end else begin
        case (i_u)
          OP_NONE: ;
          OP_LOGIN: begin
            if (logged_q) o_a_d = ST_ERR;
            else if (usr_hit) begin
              logged_d = 1'b1;
              sess_d   = usr_hit_idx;
              o_a_d    = ST_OK;
            end else o_a_d = ST_NF;
          end
          OP_LOGOUT: begin
            if (logged_q) begin
              logged_d = 1'b0;
              o_a_d    = ST_OK;
            end else o_a_d = ST_ERR;
          end
          OP_ADD_USER: begin
            if (!is_admin) o_a_d = ST_DEN;
            else if (usr_hit) o_a_d = ST_DUP;
            else if (!usr_free) o_a_d = ST_FUL;
            else begin
              user_name_d[usr_free_idx] = i_a;
              user_vld_d[usr_free_idx]  = 1'b1;
              o_a_d = ST_OK;
            end
          end
          OP_DEL_USER: begin
            if (!is_admin || i_a == ADMIN_USERNAME) o_a_d = ST_DEN;
            else if (!usr_hit) o_a_d = ST_NF;
            else begin
              user_vld_d[usr_hit_idx] = 1'b0;
              o_a_d = ST_OK;
            end
          end
          OP_ADD_ITEM: begin
            if (!is_admin) o_a_d = ST_DEN;
            else if (itm_hit) o_a_d = ST_DUP;
            else if (!itm_free) o_a_d = ST_FUL;
            else begin
              item_name_d[itm_free_idx] = i_a;
              item_vld_d[itm_free_idx]  = 1'b1;
              o_a_d = ST_OK;
            end
          end
          OP_DEL_ITEM, OP_BUY: begin
            if ((i_u == OP_DEL_ITEM) ? !is_admin : (!logged_q || is_admin)) o_a_d = ST_DEN;
            else if (!itm_hit) o_a_d = ST_NF;
            else begin
              item_vld_d[itm_hit_idx] = 1'b0;
              o_a_d = ST_OK;
            end
          end
`ifdef SHOP_WHOAMI_EN
          OP_WHOAMI: o_a_d = logged_q ? user_name_q[sess_q] : ST_ANON;
`endif
          default: o_a_d = ST_ERR;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(MAX_USERS); i++) user_name_q[i] <= '0;
      for (int i = 0; i < int'(MAX_ITEMS); i++) item_name_q[i] <= '0;
      user_name_q[0] <= ADMIN_USERNAME;
      user_vld_q     <= MAX_USERS'(1);
      item_vld_q     <= '0;
      logged_q       <= 1'b0;
      sess_q         <= '0;
      o_a_q          <= '0;
      rdy_q          <= 1'b0;
    end else begin
      user_name_q <= user_name_d;
      user_vld_q  <= user_vld_d;
      item_name_q <= item_name_d;
      item_vld_q  <= item_vld_d;
      logged_q    <= logged_d;
      sess_q      <= sess_d;
      o_a_q       <= o_a_d;
      rdy_q       <= i_rdy;
    end
  end

endmodule

// File: tb/tb_shop_v.sv
// Self-checking bench for shop_v: directed scenario plus random commands against a table model.
module tb_shop_v;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rdy;
  logic [3:0]  i_u;
  logic [23:0] i_a;
  logic [23:0] o_a;

  int checks = 0;
  int errors = 0;

  // Model: a slot is empty when its name is zero; session -1 means logged out.
  logic [23:0] m_usr [5];
  logic [23:0] m_itm [8];
  int          m_sess;
  logic [23:0] exp_oa;
  bit          chk_en;

  shop_v dut (
    .i_clk  (clk),
    .i_reset(rst),
    .i_rdy  (i_rdy),
    .i_u    (i_u),
    .i_a    (i_a),
    .o_a    (o_a)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h \"%s\" expected %h \"%s\" at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  always @(negedge clk) if (!rst && chk_en) check("o_a_vs_model", o_a, exp_oa);

  function automatic int find_usr(input logic [23:0] n);
    for (int k = 0; k < 5; k++) if (m_usr[k] == n) return k;
    return -1;
  endfunction

  function automatic int find_itm(input logic [23:0] n);
    for (int k = 0; k < 8; k++) if (m_itm[k] == n) return k;
    return -1;
  endfunction

  task automatic model_reset();
    foreach (m_usr[k]) m_usr[k] = '0;
    foreach (m_itm[k]) m_itm[k] = '0;
    m_usr[0] = "Adm";
    m_sess   = -1;
    exp_oa   = '0;
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [23:0] arg);
    int k;
    int f;
    if (op == 0) return;
    if (op != 2 && arg == 0) begin
      exp_oa = "ERR";
      return;
    end
    case (op)
      1: begin
        k = find_usr(arg);
        if (m_sess >= 0) exp_oa = "ERR";
        else if (k >= 0) begin m_sess = k; exp_oa = "OK "; end
        else exp_oa = "NF ";
      end
      2: if (m_sess >= 0) begin m_sess = -1; exp_oa = "OK "; end else exp_oa = "ERR";
      3: begin
        f = find_usr(24'h0);
        if (m_sess != 0) exp_oa = "DEN";
        else if (find_usr(arg) >= 0) exp_oa = "DUP";
        else if (f < 0) exp_oa = "FUL";
        else begin m_usr[f] = arg; exp_oa = "OK "; end
      end
      4: begin
        k = find_usr(arg);
        if (m_sess != 0 || arg == "Adm") exp_oa = "DEN";
        else if (k < 0) exp_oa = "NF ";
        else begin m_usr[k] = '0; exp_oa = "OK "; end
      end
      5: begin
        f = find_itm(24'h0);
        if (m_sess != 0) exp_oa = "DEN";
        else if (find_itm(arg) >= 0) exp_oa = "DUP";
        else if (f < 0) exp_oa = "FUL";
        else begin m_itm[f] = arg; exp_oa = "OK "; end
      end
      6, 7: begin
        k = find_itm(arg);
        if (op == 6 ? (m_sess != 0) : (m_sess <= 0)) exp_oa = "DEN";
        else if (k < 0) exp_oa = "NF ";
        else begin m_itm[k] = '0; exp_oa = "OK "; end
      end
`ifdef SHOP_WHOAMI_EN
      8: exp_oa = (m_sess < 0) ? 24'("---") : m_usr[m_sess];
`endif
      default: exp_oa = "ERR";
    endcase
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [23:0] arg, input int hold);
    @(negedge clk);
    i_u   = op;
    i_a   = arg;
    i_rdy = 1'b1;
    @(posedge clk);
    model_exec(op, arg);
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    i_rdy = 1'b0;
  endtask

  task automatic cmd_lit(input string name, input logic [3:0] op, input logic [23:0] arg,
                         input logic [23:0] lit);
    do_cmd(op, arg, 1);
    check(name, o_a, lit);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_o_a", o_a, 24'h0);
    model_reset();
    i_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  logic [23:0] pool [10];

  initial begin
    pool = '{"Adm", "Bob", "Cat", "Dan", "Eve", "Fay", "pen", "cup", "box", 24'h0};
    rst = 1'b1; i_rdy = 1'b0; i_u = '0; i_a = '0; chk_en = 1'b0;
    model_reset();
    #1 check("reset_o_a", o_a, 24'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    cmd_lit("del_user_loggedout", 4, "sd", "DEN");
    cmd_lit("add_item_loggedout", 5, "gf", "DEN");
    cmd_lit("del_item_loggedout", 6, "hh", "DEN");
    cmd_lit("buy_loggedout", 7, "hi", "DEN");
    cmd_lit("login_adm", 1, "Adm", "OK ");
    cmd_lit("add_bob", 3, "Bob", "OK ");
    cmd_lit("add_bob_dup", 3, "Bob", "DUP");
    cmd_lit("add_cat", 3, "Cat", "OK ");
    cmd_lit("add_dan", 3, "Dan", "OK ");
    cmd_lit("add_eve", 3, "Eve", "OK ");
    cmd_lit("add_fay_full", 3, "Fay", "FUL");
    cmd_lit("add_pen", 5, "pen", "OK ");
    cmd_lit("logout_adm", 2, 24'h0, "OK ");
    cmd_lit("login_bob", 1, "Bob", "OK ");
    cmd_lit("buy_pen", 7, "pen", "OK ");
    cmd_lit("buy_pen_again", 7, "pen", "NF ");
    cmd_lit("bob_add_item", 5, "cup", "DEN");
    cmd_lit("login_while_in", 1, "Adm", "ERR");
    cmd_lit("logout_bob", 2, 24'h0, "OK ");
    cmd_lit("logout_twice", 2, 24'h0, "ERR");
    cmd_lit("relogin_adm", 1, "Adm", "OK ");
    cmd_lit("del_adm", 4, "Adm", "DEN");
    cmd_lit("del_zed", 4, "Zed", "NF ");
    cmd_lit("bad_opcode", 12, "abc", "ERR");
    cmd_lit("zero_arg_login", 1, 24'h0, "ERR");
    do_cmd(5, "box", 5);
    check("hold_rdy_once", o_a, "OK ");
    cmd_lit("box_dup", 5, "box", "DUP");
    do_reset();
    cmd_lit("login_bob_after_reset", 1, "Bob", "NF ");

    for (int n = 0; n < 600; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      do_cmd(op, pool[$urandom_range(0, 9)], $urandom_range(1, 3));
      if (n == 300) do_reset();
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
